// File: rtl/fp_max_pool_reducer_if.sv
// ---------------------------------------------------------------------------
// fp_max_pool_reducer_if
// Stream bundle for the max-pool reducer: the sample input stream
// (s_valid/s_ready/s_data) and the window result stream
// (m_valid/m_ready/m_data, plus m_index when POOL_ARGMAX_EN is defined).
//   slave  : reducer side (consumes samples, produces results)
//   master : environment side (produces samples, consumes results)
// Parameters: W sample width, IDXW argmax index width.
// Optional feature macro: POOL_ARGMAX_EN (adds m_index).
// ---------------------------------------------------------------------------
interface fp_max_pool_reducer_if #(
  parameter int W    = 16,
  parameter int IDXW = 2
);
  logic            s_valid;
  logic            s_ready;
  logic [W-1:0]    s_data;
  logic            m_valid;
  logic            m_ready;
  logic [W-1:0]    m_data;
`ifdef POOL_ARGMAX_EN
  logic [IDXW-1:0] m_index;

  modport slave  (input  s_valid, s_data, m_ready,
                  output s_ready, m_valid, m_data, m_index);
  modport master (output s_valid, s_data, m_ready,
                  input  s_ready, m_valid, m_data, m_index);
`else
  modport slave  (input  s_valid, s_data, m_ready,
                  output s_ready, m_valid, m_data);
  modport master (output s_valid, s_data, m_ready,
                  input  s_ready, m_valid, m_data);
`endif
endinterface

// File: rtl/fp_max_pool_reducer.sv
// ---------------------------------------------------------------------------
// fp_max_pool_reducer
// Streaming max-pool reducer: keeps a running maximum over WINDOW accepted
// fixed-point samples and presents the window maximum (and optionally its
// position) on a registered valid/ready output stream.
// Ports:
//   clk  : single rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : fp_max_pool_reducer_if.slave
//          s_valid/s_ready/s_data  sample input stream
//          m_valid/m_ready/m_data  window maximum output stream
//          m_index                 argmax position (POOL_ARGMAX_EN only)
// Optional feature macro: POOL_ARGMAX_EN (argmax index tracking + m_index).
// ---------------------------------------------------------------------------
module fp_max_pool_reducer #(
  parameter int SIGNED   = 1,
  parameter int INTEGER  = 2,
  parameter int FRACTION = 14,
  parameter int WINDOW   = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  fp_max_pool_reducer_if.slave   bus
);
  localparam int W    = INTEGER + FRACTION;
  localparam int IDXW = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam logic [IDXW-1:0] LAST = IDXW'(WINDOW - 1);

  // Magnitude compare; the format carries no arithmetic, only ordering.
  function automatic logic gt(input logic [W-1:0] a, input logic [W-1:0] b);
    if (SIGNED != 0) return $signed(a) > $signed(b);
    else             return a > b;
  endfunction

  logic [IDXW-1:0] r_count;
  logic [W-1:0]    r_acc;
  logic            r_m_valid;
  logic [W-1:0]    r_m_data;

  logic            w_s_ready;
  logic            w_in_beat;
  logic            w_out_beat;
  logic            w_first;
  logic            w_last;
  logic            w_take;
  logic [W-1:0]    w_max;

  // Input is refused while a result is held and not being taken this cycle.
  assign w_s_ready  = !rst && (!r_m_valid || bus.m_ready);
  assign w_in_beat  = bus.s_valid && w_s_ready;
  assign w_out_beat = r_m_valid && bus.m_ready;
  assign w_first    = (r_count == '0);
  assign w_last     = (r_count == LAST);
  // Strict greater-than keeps the earliest position on ties.
  assign w_take     = w_first || gt(bus.s_data, r_acc);
  assign w_max      = w_take ? bus.s_data : r_acc;

`ifdef POOL_ARGMAX_EN
  logic [IDXW-1:0] r_acc_idx;
  logic [IDXW-1:0] r_m_index;
  logic [IDXW-1:0] w_idx;

  assign w_idx       = w_take ? r_count : r_acc_idx;
  assign bus.m_index = r_m_index;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc_idx <= '0;
      r_m_index <= '0;
    end else if (w_in_beat) begin
      r_acc_idx <= w_idx;
      if (w_last) r_m_index <= w_idx;
    end
  end
`endif

  // Accumulate / complete window / release result
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count   <= '0;
      r_acc     <= '0;
      r_m_valid <= 1'b0;
      r_m_data  <= '0;
    end else begin
      if (w_out_beat) r_m_valid <= 1'b0;
      if (w_in_beat) begin
        r_acc <= w_max;
        if (w_last) begin
          // A load in the same cycle as an output beat wins over the clear.
          r_m_data  <= w_max;
          r_m_valid <= 1'b1;
          r_count   <= '0;
        end else begin
          r_count <= r_count + 1'b1;
        end
      end
    end
  end

  assign bus.s_ready = w_s_ready;
  assign bus.m_valid = r_m_valid;
  assign bus.m_data  = r_m_data;

endmodule

// File: tb/tb_fp_max_pool_reducer.sv
module tb_fp_max_pool_reducer;
  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  fp_max_pool_reducer_if #(.W(16), .IDXW(2)) a ();
  fp_max_pool_reducer_if #(.W(16), .IDXW(2)) b ();

  fp_max_pool_reducer #(.SIGNED(1), .INTEGER(2), .FRACTION(14), .WINDOW(4))
    u_sgn (.clk(clk), .rst(rst), .bus(a.slave));
  fp_max_pool_reducer #(.SIGNED(0), .INTEGER(2), .FRACTION(14), .WINDOW(4))
    u_uns (.clk(clk), .rst(rst), .bus(b.slave));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Offer one sample on the selected stream (called at a negedge) and
  // return at the negedge after the accepting edge.
  task automatic push(input bit sel, input logic [15:0] d);
    int n;
    logic rdy;
    n = 0;
    if (sel) begin b.s_valid = 1'b1; b.s_data = d; end
    else     begin a.s_valid = 1'b1; a.s_data = d; end
    #1;
    rdy = sel ? b.s_ready : a.s_ready;
    while (!rdy && n < 50) begin
      @(negedge clk); #1;
      rdy = sel ? b.s_ready : a.s_ready;
      n++;
    end
    if (!rdy) check("push_timeout", 32'd0, 32'd1);
    @(negedge clk);
    if (sel) b.s_valid = 1'b0; else a.s_valid = 1'b0;
  endtask

  // Take the held result with a one-cycle m_ready pulse.
  task automatic pop(input bit sel);
    if (sel) b.m_ready = 1'b1; else a.m_ready = 1'b1;
    #1;
    check("pop_s_ready", sel ? b.s_ready : a.s_ready, 1);
    @(negedge clk);
    if (sel) b.m_ready = 1'b0; else a.m_ready = 1'b0;
    #1;
    check("pop_m_valid_drop", sel ? b.m_valid : a.m_valid, 0);
  endtask

  logic [15:0] sd [16];
  logic [15:0] smax [4];
  logic [1:0]  sidx [4];
  int          nres;
  int          grp;

  initial begin
    rst = 1'b1;
    a.s_valid = 1'b0; a.s_data = '0; a.m_ready = 1'b0;
    b.s_valid = 1'b0; b.s_data = '0; b.m_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_m_valid", a.m_valid, 0);
    check("rst_m_data",  a.m_data, 0);
    check("rst_s_ready", a.s_ready, 0);
`ifdef POOL_ARGMAX_EN
    check("rst_m_index", a.m_index, 0);
`endif
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("post_rst_s_ready", a.s_ready, 1);

    // 1: signed, tie keeps earliest
    push(0, 16'h1000); push(0, 16'hC000); push(0, 16'h2000);
    check("t1_not_yet_valid", a.m_valid, 0);
    push(0, 16'h2000);
    check("t1_m_valid", a.m_valid, 1);
    check("t1_m_data", a.m_data, 16'h2000);
`ifdef POOL_ARGMAX_EN
    check("t1_m_index", a.m_index, 2);
`endif

    // 4: backpressure, offered sample must not be taken
    a.s_valid = 1'b1; a.s_data = 16'h7FFF;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("t4_s_ready", a.s_ready, 0);
      check("t4_m_valid", a.m_valid, 1);
      check("t4_m_data", a.m_data, 16'h2000);
      @(negedge clk);
    end
    a.s_valid = 1'b0;
    pop(0);

    // 2: signed, all negative
    push(0, 16'h8000); push(0, 16'hFFFF); push(0, 16'hC000); push(0, 16'h8001);
    check("t2_m_valid", a.m_valid, 1);
    check("t2_m_data", a.m_data, 16'hFFFF);
`ifdef POOL_ARGMAX_EN
    check("t2_m_index", a.m_index, 1);
`endif

    // output beat and first sample of next window in one cycle
    a.m_ready = 1'b1; a.s_valid = 1'b1; a.s_data = 16'h0005;
    #1;
    check("nb_s_ready", a.s_ready, 1);
    @(negedge clk);
    a.m_ready = 1'b0; a.s_valid = 1'b0;
    #1;
    check("nb_m_valid_drop", a.m_valid, 0);
    push(0, 16'h0003); push(0, 16'h0005); push(0, 16'h0001);
    check("nb_m_valid", a.m_valid, 1);
    check("nb_m_data", a.m_data, 16'h0005);
`ifdef POOL_ARGMAX_EN
    check("nb_m_index", a.m_index, 0);
`endif
    pop(0);

    // 3: unsigned compare
    push(1, 16'h7FFF); push(1, 16'h8000); push(1, 16'h0000); push(1, 16'h0001);
    check("t3_m_valid", b.m_valid, 1);
    check("t3_m_data", b.m_data, 16'h8000);
`ifdef POOL_ARGMAX_EN
    check("t3_m_index", b.m_index, 1);
`endif
    pop(1);

    // 5: reset mid-window, idle gaps between samples afterwards
    push(0, 16'h3000); push(0, 16'h3FFF);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    push(0, 16'h0100);
    @(negedge clk);
    push(0, 16'h0200);
    repeat (2) @(negedge clk);
    push(0, 16'h0300);
    check("t5_not_yet_valid", a.m_valid, 0);
    push(0, 16'h0050);
    check("t5_m_valid", a.m_valid, 1);
    check("t5_m_data", a.m_data, 16'h0300);
`ifdef POOL_ARGMAX_EN
    check("t5_m_index", a.m_index, 2);
`endif

    // reset while a result is held
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("hold_rst_m_valid", a.m_valid, 0);
    check("hold_rst_m_data", a.m_data, 0);

    // 6: continuous streaming
    sd = '{16'h0001, 16'h0010, 16'h0100, 16'h1000,
           16'h7FFF, 16'h0000, 16'h8000, 16'h7FFE,
           16'hFFFE, 16'hFFFF, 16'hFFFD, 16'hFFFF,
           16'h0300, 16'h0200, 16'h0400, 16'h0100};
    smax = '{16'h1000, 16'h7FFF, 16'hFFFF, 16'h0400};
    sidx = '{2'd3, 2'd0, 2'd1, 2'd2};
    nres = 0;
    a.m_ready = 1'b1;
    for (int i = 0; i <= 17; i++) begin
      #1;
      if (a.m_valid) begin
        grp = (i / 4) - 1;
        if (i % 4 == 0 && grp >= 0 && grp < 4) begin
          check("t6_m_data", a.m_data, smax[grp]);
`ifdef POOL_ARGMAX_EN
          check("t6_m_index", a.m_index, sidx[grp]);
`endif
        end else begin
          check("t6_unexpected_valid_cycle", i, 0);
        end
        nres++;
      end
      if (i < 16) begin
        a.s_valid = 1'b1; a.s_data = sd[i];
        #1;
        check("t6_s_ready", a.s_ready, 1);
      end else begin
        a.s_valid = 1'b0;
      end
      @(negedge clk);
    end
    a.m_ready = 1'b0;
    check("t6_result_count", nres, 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
